// File: rtl/cpu_clk_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : cpu_clk_ctrl
// Brief   : CPU clock-enable controller with run / single-step / halt gating,
//           tap-selectable tick source and debounced step button.
// Revision: 1.0 - initial release
// ============================================================================
module cpu_clk_ctrl #(
    parameter int DB_CYCLES = 50000,
    parameter int DB_W      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] clkdiv,
    input  logic [4:0]  sel_tap,
    input  logic        run_mode,
    input  logic        step_btn,
    input  logic        halt,
    input  logic        resume,
    output logic        cpu_ce,
    output logic [1:0]  state,
    output logic [15:0] ce_cnt
);

    localparam logic [DB_W-1:0] c_DB_LAST = DB_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10,
        S_HALT = 2'b11
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_ce_next;
    logic              r_cpu_ce;
    logic [15:0]       r_ce_cnt;

    logic              r_tap_prev;
    logic [4:0]        r_sel_q;
    logic              w_tick;

    logic              r_sync1;
    logic              r_btn_s;
    logic              r_btn_stable;
    logic              r_btn_stable_q;
    logic [DB_W-1:0]   r_db_cnt;
    logic              w_step_req;

    // A tap change invalidates r_tap_prev, so the edge detect is suppressed for that cycle.
    assign w_tick     = clkdiv[sel_tap] & ~r_tap_prev & (sel_tap == r_sel_q);
    assign w_step_req = r_btn_stable & ~r_btn_stable_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tap_prev <= 1'b0;
            r_sel_q    <= '0;
        end else begin
            r_tap_prev <= clkdiv[sel_tap];
            r_sel_q    <= sel_tap;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1        <= 1'b0;
            r_btn_s        <= 1'b0;
            r_btn_stable   <= 1'b0;
            r_btn_stable_q <= 1'b0;
            r_db_cnt       <= '0;
        end else begin
            r_sync1        <= step_btn;
            r_btn_s        <= r_sync1;
            r_btn_stable_q <= r_btn_stable;
            if (r_btn_s == r_btn_stable) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_DB_LAST) begin
                r_btn_stable <= r_btn_s;
                r_db_cnt     <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cpu_ce <= 1'b0;
            r_ce_cnt <= '0;
        end else begin
            r_state  <= w_state_next;
            r_cpu_ce <= w_ce_next;
            r_ce_cnt <= r_ce_cnt + 16'(r_cpu_ce);
        end
    end

    // Halt overrides every state; step requests outside IDLE are dropped.
    always_comb begin
        w_state_next = r_state;
        w_ce_next    = 1'b0;
        if (halt) begin
            w_state_next = S_HALT;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run_mode)        w_state_next = S_RUN;
                    else if (w_step_req) w_state_next = S_STEP;
                end
                S_RUN: begin
                    if (!run_mode) w_state_next = S_IDLE;
                    else           w_ce_next    = w_tick;
                end
                S_STEP: begin
                    if (w_tick) begin
                        w_ce_next    = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
                S_HALT: begin
                    if (resume) w_state_next = S_IDLE;
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    assign cpu_ce = r_cpu_ce;
    assign state  = r_state;
    assign ce_cnt = r_ce_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cpu_clk_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpu_clk_ctrl
// Brief   : Self-checking bench for cpu_clk_ctrl against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cpu_clk_ctrl;

    localparam int DB = 4;
    localparam int c_IDLE = 0;
    localparam int c_RUN  = 1;
    localparam int c_STEP = 2;
    localparam int c_HALT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] clkdiv = '0;
    logic [4:0]  sel_tap = '0;
    logic        run_mode = 1'b0;
    logic        step_btn = 1'b0;
    logic        halt = 1'b0;
    logic        resume = 1'b0;
    logic        cpu_ce;
    logic [1:0]  state;
    logic [15:0] ce_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Model of the controller, kept in plain terms of the operating rules
    int          m_state = c_IDLE;
    bit          m_ce = 1'b0;
    bit [15:0]   m_cnt = '0;
    bit          m_sync1 = 1'b0, m_btn_s = 1'b0, m_stable = 1'b0, m_stable_prev = 1'b0;
    int          m_run = 0;
    bit [31:0]   m_prev_div = '0;
    int          m_prev_sel = 0;

    cpu_clk_ctrl #(.DB_CYCLES(DB), .DB_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .clkdiv   (clkdiv),
        .sel_tap  (sel_tap),
        .run_mode (run_mode),
        .step_btn (step_btn),
        .halt     (halt),
        .resume   (resume),
        .cpu_ce   (cpu_ce),
        .state    (state),
        .ce_cnt   (ce_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Predict the outputs of the next cycle from the inputs applied now.
    task automatic mstep();
        bit tick, req, nce;
        int ns;
        if (rst) begin
            m_state = c_IDLE; m_ce = 1'b0; m_cnt = '0;
            m_sync1 = 1'b0; m_btn_s = 1'b0; m_stable = 1'b0; m_stable_prev = 1'b0;
            m_run = 0; m_prev_div = '0; m_prev_sel = 0;
        end else begin
            tick = clkdiv[sel_tap] && !m_prev_div[sel_tap] && (int'(sel_tap) == m_prev_sel);
            req  = m_stable && !m_stable_prev;
            ns   = m_state;
            nce  = 1'b0;
            if (halt)                  ns = c_HALT;
            else if (m_state == c_IDLE) ns = run_mode ? c_RUN : (req ? c_STEP : c_IDLE);
            else if (m_state == c_RUN) begin
                if (!run_mode) ns = c_IDLE;
                else           nce = tick;
            end else if (m_state == c_STEP) begin
                if (tick) begin nce = 1'b1; ns = c_IDLE; end
            end else if (resume)        ns = c_IDLE;
            m_cnt   = m_cnt + 16'(m_ce);
            m_state = ns;
            m_ce    = nce;
            m_stable_prev = m_stable;
            if (m_btn_s != m_stable) begin
                m_run++;
                if (m_run == DB) begin m_stable = m_btn_s; m_run = 0; end
            end else begin
                m_run = 0;
            end
            m_btn_s    = m_sync1;
            m_sync1    = step_btn;
            m_prev_div = clkdiv;
            m_prev_sel = int'(sel_tap);
        end
    endtask

    task automatic next_cycle();
        mstep();
        @(negedge clk);
        chk("state",  int'(state),  m_state);
        chk("cpu_ce", int'(cpu_ce), int'(m_ce));
        chk("ce_cnt", int'(ce_cnt), int'(m_cnt));
        clkdiv = clkdiv + 32'd1;
    endtask

    initial begin
        int pulses, first, steps, prev_st;
        bit found, tgt;

        // Reset
        rst = 1'b1;
        next_cycle();
        next_cycle();
        chk("rst_state", int'(state), 0);
        chk("rst_ce",    int'(cpu_ce), 0);
        chk("rst_cnt",   int'(ce_cnt), 0);

        // Run mode, tap 2, clkdiv from 0
        rst = 1'b0; run_mode = 1'b1; sel_tap = 5'd2; clkdiv = '0;
        pulses = 0; first = -1;
        for (int k = 1; k <= 32; k++) begin
            next_cycle();
            if (k == 1) chk("run_state", int'(state), 1);
            if (cpu_ce) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        chk("run_first_ce", first, 5);
        chk("run_pulses", pulses, 4);
        chk("run_cnt", int'(ce_cnt), 4);

        // Halt in the same cycle as a tick
        for (int k = 0; k < 8 && clkdiv[2:0] != 3'd4; k++) next_cycle();
        halt = 1'b1;
        next_cycle();
        chk("halt_ce", int'(cpu_ce), 0);
        chk("halt_state", int'(state), 3);
        resume = 1'b1;
        next_cycle();
        chk("halt_resume_both", int'(state), 3);
        halt = 1'b0;
        next_cycle();
        chk("resume_idle", int'(state), 0);
        resume = 1'b0;
        next_cycle();

        // Tap change 3 -> 0 while clkdiv[0]=1, clkdiv[3]=0
        sel_tap = 5'd3;
        for (int k = 0; k < 10; k++) next_cycle();
        for (int k = 0; k < 16 && !(clkdiv[0] && !clkdiv[3]); k++) next_cycle();
        sel_tap = 5'd0;
        next_cycle();
        chk("tap_change_ce", int'(cpu_ce), 0);
        next_cycle();
        next_cycle();
        chk("tap_first_ce", int'(cpu_ce), 1);
        for (int k = 0; k < 6; k++) next_cycle();

        // Counter wrap
        for (int k = 0; k < 4 && cpu_ce; k++) next_cycle();
        force dut.r_ce_cnt = 16'hFFFF;
        #1;
        release dut.r_ce_cnt;
        m_cnt = 16'hFFFF;
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            next_cycle();
            if (cpu_ce) begin
                next_cycle();
                chk("wrap_cnt", int'(ce_cnt), 0);
                found = 1'b1;
            end
        end
        if (!found) chk("wrap_timeout", 0, 1);

        // Single step with a bouncing button
        run_mode = 1'b0; sel_tap = 5'd1; step_btn = 1'b0;
        for (int k = 0; k < 4; k++) next_cycle();
        steps = 0;
        for (int k = 0; k < 12; k++) begin
            step_btn = ((k / 2) % 2) == 1;
            next_cycle();
            if (state == 2'd2) steps++;
        end
        chk("bounce_no_step", steps, 0);
        step_btn = 1'b1; pulses = 0; prev_st = int'(state);
        for (int k = 0; k < 20; k++) begin
            next_cycle();
            if (cpu_ce) pulses++;
            if (state == 2'd2 && prev_st != 2) steps++;
            prev_st = int'(state);
        end
        chk("step_entries", steps, 1);
        chk("step_pulses", pulses, 1);
        chk("step_back_idle", int'(state), 0);

        // Second press during STEP is dropped
        step_btn = 1'b0; sel_tap = 5'd5;
        for (int k = 0; k < 8; k++) next_cycle();
        clkdiv = '0; pulses = 0;
        for (int k = 0; k < 70; k++) begin
            step_btn = (k < 8) || (k >= 16);
            next_cycle();
            if (cpu_ce) pulses++;
            if (k + 1 == 23) chk("step_held_after_req", int'(state), 2);
        end
        chk("drop_pulses", pulses, 1);
        chk("drop_idle", int'(state), 0);

        // Reset mid-step
        step_btn = 1'b0;
        for (int k = 0; k < 8; k++) next_cycle();
        clkdiv = '0; step_btn = 1'b1;
        for (int k = 0; k < 10; k++) next_cycle();
        chk("pre_rst_step", int'(state), 2);
        rst = 1'b1; step_btn = 1'b0;
        next_cycle();
        chk("midrst_state", int'(state), 0);
        chk("midrst_ce", int'(cpu_ce), 0);
        chk("midrst_cnt", int'(ce_cnt), 0);
        rst = 1'b0; pulses = 0;
        for (int k = 0; k < 70; k++) begin
            next_cycle();
            if (cpu_ce) pulses++;
        end
        chk("post_rst_pulses", pulses, 0);

        // Randomized traffic
        clkdiv = $urandom; tgt = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom % 400) == 0;
            if (($urandom % 60) == 0) run_mode = ~run_mode;
            if (($urandom % 50) == 0) sel_tap = 5'($urandom % 6);
            if (halt) halt = ($urandom % 4) != 0;
            else      halt = ($urandom % 40) == 0;
            resume = ($urandom % 3) == 0;
            if (($urandom % 25) == 0) tgt = ~tgt;
            step_btn = tgt ^ (($urandom % 5) == 0);
            next_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
